muldiv_sequencer: RTL

- Iterative RV32M multiply/divide engine and its controller, sitting beside the ALU in the execute stage.
- Accepts one M-extension op from EX and holds the pipeline for the duration of the operation.
- Returns a 32-bit result to the EX result mux for one cycle.
- Its stall output is ORed into the pipeline stall/flush logic next to the forwarding and hazard network.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 49 ++++
 rtl/muldiv_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the RV32M multiply/divide engine.
//   state_t      - controller states (IDLE, CALC, DONE)
//   F3_*         - RV32M funct3 encodings
//   is_signed_a  - rs1 is a signed operand for this funct3
//   is_signed_b  - rs2 is a signed operand for this funct3
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // MUL only returns the low word, which is the same for signed and
  // unsigned operands, so it is handled as unsigned.
  function automatic logic is_signed_a(input logic [2:0] f3);
    logic res;
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    logic res;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: res = 1'b1;
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration on unsigned magnitudes.
//   is_div   - 1: restoring shift-subtract step, 0: shift-add step
//   hi       - multiply: accumulator high word / divide: partial remainder
//   lo       - multiply: multiplier (shifted out LSB first) / divide:
//              dividend shifting out MSB first, quotient shifting in
//   operand  - multiplicand or divisor magnitude
//   hi_next, lo_next - register values after this iteration
// After XLEN iterations {hi,lo} is the product, or hi = remainder and
// lo = quotient.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] trial_s;

  // Single multiply or divide iteration selected by is_div.
  always_comb begin
    sum_s   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    // Bit XLEN of the trial difference is the borrow: set means the
    // shifted remainder is smaller than the divisor and is restored.
    trial_s = {hi, lo[XLEN-1]} - {1'b0, operand};
    hi_next = hi;
    lo_next = lo;
    if (is_div) begin
      if (!trial_s[XLEN]) begin
        hi_next = trial_s[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = {hi[XLEN-2:0], lo[XLEN-1]};
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // The carry out of the add becomes the accumulator MSB after the shift.
      hi_next = sum_s[XLEN:1];
      lo_next = {sum_s[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide engine for EX.
//   clk, rst_n      - pipeline clock, asynchronous active-low reset
//   start           - EX holds a valid M-extension instruction
//   funct3          - RV32M operation select
//   op_a, op_b      - forwarded rs1 / rs2 values
//   flush           - abort the in-flight op (pipeline redirect)
//   stall_pipeline  - freeze PC, IF/ID and ID/EX while the op runs
//   busy            - controller not in IDLE
//   result_valid    - result is valid this cycle (one cycle per op)
//   result          - product word, quotient or remainder; holds until the
//                     next completed op
// Operands are converted to magnitudes on acceptance, iterated for XLEN
// cycles, and the sign is restored while the result is registered on the
// way into DONE. Divide-by-zero and signed overflow skip the iteration.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall_pipeline,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]   ZERO_W    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_W    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ONE_W     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   MIN_W     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ONE_D     = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v);
    return ~v + ONE_D;
  endfunction

  state_t            state_r;
  state_t            state_n_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        f3_r;
  logic              neg_a_r;
  logic              neg_b_r;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic [XLEN-1:0]   opb_r;
  logic [XLEN-1:0]   result_r;
  logic              result_valid_r;

  logic              accept_s;
  logic              last_s;
  logic              neg_a_s;
  logic              neg_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              special_s;
  logic [XLEN-1:0]   special_res_s;
  logic [XLEN-1:0]   hi_step_s;
  logic [XLEN-1:0]   lo_step_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_s;

  assign accept_s = (state_r == IDLE) && start && !flush;
  assign last_s   = (cnt_r == LAST_CNT);

  // Operand magnitudes, signs and the divide special cases seen in IDLE.
  always_comb begin
    neg_a_s    = is_signed_a(funct3) & op_a[XLEN-1];
    neg_b_s    = is_signed_b(funct3) & op_b[XLEN-1];
    mag_a_s    = neg_a_s ? neg_w(op_a) : op_a;
    mag_b_s    = neg_b_s ? neg_w(op_b) : op_b;
    div_zero_s = funct3[2] && (op_b == ZERO_W);
    // Only DIV and REM are both divides and signed on rs1.
    div_ovf_s  = funct3[2] && is_signed_a(funct3) &&
                 (op_a == MIN_W) && (op_b == ONES_W);
    special_s  = div_zero_s || div_ovf_s;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (div_zero_s) begin
      special_res_s = funct3[1] ? op_a : ONES_W;
    end else if (div_ovf_s) begin
      special_res_s = funct3[1] ? ZERO_W : MIN_W;
    end else begin
      special_res_s = ZERO_W;
    end
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div  (f3_r[2]),
    .hi      (hi_r),
    .lo      (lo_r),
    .operand (opb_r),
    .hi_next (hi_step_s),
    .lo_next (lo_step_s)
  );

  // Sign fix-up and word selection on the final iteration's output.
  always_comb begin
    prod_s = {hi_step_s, lo_step_s};
    if (neg_a_r ^ neg_b_r) begin
      prod_s = neg_d({hi_step_s, lo_step_s});
      quo_s  = neg_w(lo_step_s);
    end else begin
      quo_s  = lo_step_s;
    end
    // The remainder follows the dividend's sign.
    if (neg_a_r) begin
      rem_s = neg_w(hi_step_s);
    end else begin
      rem_s = hi_step_s;
    end
    case (f3_r)
      F3_MUL:                        final_s = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  final_s = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               final_s = quo_s;
      F3_REM, F3_REMU:               final_s = rem_s;
      default:                       final_s = ZERO_W;
    endcase
  end

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_n_s = IDLE;
        end else if (start) begin
          state_n_s = special_s ? DONE : CALC;
        end else begin
          state_n_s = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_n_s = IDLE;
        end else if (last_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = CALC;
        end
      end
      DONE:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State, iteration datapath and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= ZERO_CNT;
      f3_r           <= 3'b000;
      neg_a_r        <= 1'b0;
      neg_b_r        <= 1'b0;
      hi_r           <= ZERO_W;
      lo_r           <= ZERO_W;
      opb_r          <= ZERO_W;
      result_r       <= ZERO_W;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_n_s;
      result_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            f3_r    <= funct3;
            neg_a_r <= neg_a_s;
            neg_b_r <= neg_b_s;
            hi_r    <= ZERO_W;
            lo_r    <= mag_a_s;
            opb_r   <= mag_b_s;
            cnt_r   <= ZERO_CNT;
            if (special_s) begin
              result_r       <= special_res_s;
              result_valid_r <= 1'b1;
            end
          end
        end
        CALC: begin
          hi_r  <= hi_step_s;
          lo_r  <= lo_step_s;
          cnt_r <= cnt_r + ONE_CNT;
          // The result is fixed up and registered as DONE is entered so
          // that it is presented from a flop during the DONE cycle.
          if (last_s && !flush) begin
            result_r       <= final_s;
            result_valid_r <= 1'b1;
          end
        end
        DONE: begin
          cnt_r <= ZERO_CNT;
        end
        default: begin
          cnt_r <= ZERO_CNT;
        end
      endcase
    end
  end

  // A flush in DONE still suppresses the result to the pipeline.
  assign result_valid   = result_valid_r && !flush;
  assign result         = result_r;
  assign busy           = (state_r != IDLE);
  assign stall_pipeline = rst_n && !flush &&
                          (((state_r == IDLE) && start) || (state_r == CALC));

endmodule
